// File: rtl/mem_cache_bridge.sv
// Direct-mapped, one-word-per-line, write-through/write-allocate cache between the CPU and slow memory.
// Latency: read hit returns in the request cycle; read miss takes MEM_WAIT+1 cycles; write takes 2 cycles.
// Backpressure: cpu_ready pulses once per completed request; the CPU holds its request until then.
module mem_cache_bridge #(
   parameter int IDX_BITS = 4,
   parameter int MEM_WAIT = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic        cpu_read,
   input  logic        cpu_write,
   input  logic [31:0] cpu_write_data,
   output logic [31:0] cpu_read_data,
   output logic        cpu_ready,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   localparam int LINES = 2 ** IDX_BITS;
   localparam int TAG_W = 30 - IDX_BITS;
   localparam int CW    = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

   typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [31:0]         hit_cnt_q, hit_cnt_d;
   logic [31:0]         miss_cnt_q, miss_cnt_d;
   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [31:0]         data_q [LINES];

   logic [IDX_BITS-1:0] cpu_idx, line_idx;
   logic [TAG_W-1:0]    cpu_tag, line_tag;
   logic                hit;
   logic                line_we;
   logic [31:0]         line_data;

   // Lookup uses the live CPU address; line updates use the latched memory address.
   assign cpu_idx  = cpu_addr[IDX_BITS+1:2];
   assign cpu_tag  = cpu_addr[31:IDX_BITS+2];
   assign line_idx = mem_addr_q[IDX_BITS+1:2];
   assign line_tag = mem_addr_q[31:IDX_BITS+2];
   assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

   // Next-state, counter and CPU/memory strobe decode.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      cpu_ready     = 1'b0;
      cpu_read_data = 32'h0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      line_we       = 1'b0;
      line_data     = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (cpu_write) begin
               // Write wins over a simultaneous read; it always goes through to memory.
               mem_addr_d  = cpu_addr;
               mem_wdata_d = cpu_write_data;
               state_d     = WRITE;
               if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
               else     miss_cnt_d = miss_cnt_q + 32'd1;
            end else if (cpu_read) begin
               if (hit) begin
                  cpu_ready     = 1'b1;
                  cpu_read_data = data_q[cpu_idx];
                  hit_cnt_d     = hit_cnt_q + 32'd1;
               end else begin
                  mem_addr_d = cpu_addr;
                  cnt_d      = '0;
                  miss_cnt_d = miss_cnt_q + 32'd1;
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            mem_read = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(MEM_WAIT - 1)) begin
               // Memory data is now stable: forward it and fill the line on this edge.
               cpu_ready     = 1'b1;
               cpu_read_data = mem_read_data;
               line_we       = 1'b1;
               line_data     = mem_read_data;
               state_d       = IDLE;
            end
         end
         WRITE: begin
            mem_write = 1'b1;
            cpu_ready = 1'b1;
            line_we   = 1'b1;
            line_data = mem_wdata_q;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state, memory-side registers, valid bits and performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mem_addr_q <= 32'h0;
         mem_wdata_q <= 32'h0;
         hit_cnt_q  <= 32'h0;
         miss_cnt_q <= 32'h0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mem_addr_q <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         if (line_we) valid_q[line_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; a reset on the fill/write edge cancels the update.
   always_ff @(posedge clk) begin
      if (!reset && line_we) begin
         tag_q[line_idx]  <= line_tag;
         data_q[line_idx] <= line_data;
      end
   end

endmodule

// File: tb/tb_mem_cache_bridge.sv
// Directed self-checking bench for mem_cache_bridge with a small word-addressed memory model.
// Latency: expectations are in cycles counted from the request cycle (cycle 1).
// Backpressure: each access holds its request until cpu_ready, then drops it.
module tb_mem_cache_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr;
   logic        cpu_read;
   logic        cpu_write;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        cpu_ready;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_data;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:63];

   always #5 clk = ~clk;

   mem_cache_bridge #(.IDX_BITS(4), .MEM_WAIT(3)) dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_addr       (cpu_addr),
      .cpu_read       (cpu_read),
      .cpu_write      (cpu_write),
      .cpu_write_data (cpu_write_data),
      .cpu_read_data  (cpu_read_data),
      .cpu_ready      (cpu_ready),
      .mem_addr       (mem_addr),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   // Memory model: word-addressed, writes on posedge, reads combinational while strobed.
   assign mem_read_data = mem_read ? mem[mem_addr[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
         mem[16] <= 32'h1111_2222;
         mem[17] <= 32'h0;
         mem[32] <= 32'h3333_4444;
      end else if (mem_write) begin
         mem[mem_addr[7:2]] <= mem_write_data;
      end
   end

   // Drives one request, counts cycles until cpu_ready (0 = no ready within budget).
   task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output int cycles,
                             output logic [31:0] rdata, output int mrd, output int mwr,
                             output logic [31:0] maddr);
      cycles = 0; rdata = 32'h0; mrd = 0; mwr = 0; maddr = 32'h0;
      @(negedge clk);
      cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_write_data = wdata;
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (mem_read) mrd++;
         if (mem_write) begin mwr++; maddr = mem_addr; end
         if (cpu_ready) begin cycles = c; rdata = cpu_read_data; break; end
         @(negedge clk);
      end
      @(negedge clk);
      cpu_read = 1'b0; cpu_write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0;
      cpu_addr = 32'h0; cpu_write_data = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
      checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL reset_strobes: got rd=%b wr=%b want 0 0", mem_read, mem_write); end
      checks++; if (mem_addr !== 32'h0 || mem_write_data !== 32'h0) begin errors++; $display("FAIL reset_mem_regs: got addr=%h data=%h want 0 0", mem_addr, mem_write_data); end
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL reset_counters: got hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
      checks++; if (cpu_read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", cpu_read_data); end
   endtask

   task automatic test_read_miss();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 4) begin errors++; $display("FAIL miss_latency: got %0d want 4", cyc); end
      checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL miss_data: got %h want 11112222", rd); end
      checks++; if (mrd !== 3) begin errors++; $display("FAIL miss_mem_read_cycles: got %0d want 3", mrd); end
      checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin errors++; $display("FAIL miss_counters: got hit=%0d miss=%0d want 0 1", hit_count, miss_count); end
   endtask

   task automatic test_read_hit();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency: got %0d want 1", cyc); end
      checks++; if (rd !== 32'h1111_2222) begin errors++; $display("FAIL hit_data: got %h want 11112222", rd); end
      checks++; if (mrd !== 0) begin errors++; $display("FAIL hit_no_mem_read: got %0d want 0", mrd); end
      checks++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL hit_counters: got hit=%0d miss=%0d want 1 1", hit_count, miss_count); end
   endtask

   task automatic test_write_allocate();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL write_latency: got %0d want 2", cyc); end
      checks++; if (mwr !== 1) begin errors++; $display("FAIL write_strobe_cycles: got %0d want 1", mwr); end
      checks++; if (ma !== 32'h44) begin errors++; $display("FAIL write_mem_addr: got %h want 44", ma); end
      checks++; if (mem[17] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_mem_word17: got %h want deadbeef", mem[17]); end
      checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL write_miss_count: got %0d want 2", miss_count); end
      cpu_access(1'b1, 1'b0, 32'h44, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 1 || rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL write_then_hit: got cyc=%0d data=%h want 1 deadbeef", cyc, rd); end
      checks++; if (hit_count !== 32'd2) begin errors++; $display("FAIL write_then_hit_count: got %0d want 2", hit_count); end
   endtask

   task automatic test_conflict();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b1, 1'b0, 32'h80, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 4 || rd !== 32'h3333_4444) begin errors++; $display("FAIL conflict_0x80: got cyc=%0d data=%h want 4 33334444", cyc, rd); end
      cpu_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 4 || rd !== 32'h1111_2222) begin errors++; $display("FAIL conflict_0x40_refill: got cyc=%0d data=%h want 4 11112222", cyc, rd); end
      checks++; if (miss_count !== 32'd4 || hit_count !== 32'd2) begin errors++; $display("FAIL conflict_counters: got hit=%0d miss=%0d want 2 4", hit_count, miss_count); end
   endtask

   task automatic test_write_hit();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b0, 1'b1, 32'h40, 32'h0BAD_F00D, cyc, rd, mrd, mwr, ma);
      checks++; if (hit_count !== 32'd3 || miss_count !== 32'd4) begin errors++; $display("FAIL write_hit_counters: got hit=%0d miss=%0d want 3 4", hit_count, miss_count); end
      cpu_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 1 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL write_hit_update: got cyc=%0d data=%h want 1 0badf00d", cyc, rd); end
   endtask

   task automatic test_reset_mid_fill();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      @(negedge clk);
      cpu_read = 1'b1; cpu_addr = 32'h48;
      #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL abort_req_cycle_ready: got %b want 0", cpu_ready); end
      @(negedge clk); #1;
      checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL abort_fill_started: got %b want 1", mem_read); end
      @(negedge clk);
      reset = 1'b1; cpu_read = 1'b0;
      #1;
      checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL abort_fill2_ready: got %b want 0", cpu_ready); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (mem_read !== 1'b0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL abort_after_reset: got rd=%b rdy=%b want 0 0", mem_read, cpu_ready); end
      checks++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL abort_counters_cleared: got hit=%0d miss=%0d want 0 0", hit_count, miss_count); end
      cpu_access(1'b1, 1'b0, 32'h40, 32'h0, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 4 || rd !== 32'h1111_2222) begin errors++; $display("FAIL abort_reread_miss: got cyc=%0d data=%h want 4 11112222", cyc, rd); end
      checks++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin errors++; $display("FAIL abort_reread_counters: got hit=%0d miss=%0d want 0 1", hit_count, miss_count); end
   endtask

   task automatic test_read_write_priority();
      int cyc, mrd, mwr; logic [31:0] rd, ma;
      cpu_access(1'b1, 1'b1, 32'h4C, 32'h5, cyc, rd, mrd, mwr, ma);
      checks++; if (cyc !== 2) begin errors++; $display("FAIL prio_latency: got %0d want 2", cyc); end
      checks++; if (mrd !== 0 || mwr !== 1) begin errors++; $display("FAIL prio_strobes: got rd_cycles=%0d wr_cycles=%0d want 0 1", mrd, mwr); end
      checks++; if (mem[19] !== 32'h5) begin errors++; $display("FAIL prio_mem_word19: got %h want 5", mem[19]); end
      checks++; if (miss_count !== 32'd2) begin errors++; $display("FAIL prio_miss_count: got %0d want 2", miss_count); end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_read_hit();
      test_write_allocate();
      test_conflict();
      test_write_hit();
      test_reset_mid_fill();
      test_read_write_priority();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
